// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared encodings and decode helpers for the RV32I multicycle controller
package rv32i_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SLL = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SRA = 4'b1000
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Controller states; the numeric values carry no meaning beyond uniqueness.
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_LUI      = 4'd9;
    localparam logic [3:0] S_AUIPC    = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JALRADR  = 4'd12;
    localparam logic [3:0] S_JAL      = 4'd13;
    localparam logic [3:0] S_ILLEGAL  = 4'd14;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // True when the core implements this op/funct combination. Unsigned compares,
    // unsigned branches, non-word memory accesses and the reserved SLLI form are rejected.
    function automatic logic instr_legal(input logic [6:0] op, input logic [2:0] funct3,
                                         input logic funct7b5);
        case (op)
            OP_LOAD, OP_STORE: return funct3 == 3'b010;
            OP_RTYPE:          return funct3 != 3'b011;
            OP_ITYPE:          return (funct3 != 3'b011) && !((funct3 == 3'b001) && funct7b5);
            OP_BRANCH:         return (funct3 == 3'b000) || (funct3 == 3'b001) ||
                                      (funct3 == 3'b100) || (funct3 == 3'b101);
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_alu_dec.sv
// rtl/rv32i_alu_dec.sv - funct3/funct7b5 to ALUControl decode for R-type and I-type ALU ops
module rv32i_alu_dec
    import rv32i_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] alu_control
);

    // funct7b5 selects SUB only for register ops (for addi it is immediate bits),
    // but selects SRA for both shift forms.
    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b100:  alu_control = ALU_XOR;
            3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv32i_mc_controller.sv
// rtl/rv32i_mc_controller.sv - multicycle control FSM for the RV32I core
module rv32i_mc_controller
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       Illegal
);

    logic [3:0] state;
    logic [3:0] state_next;
    logic [3:0] dec_alu;
    logic       is_rtype;

    assign is_rtype = (state == S_EXECR);

    rv32i_alu_dec u_alu_dec (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (is_rtype),
        .alu_control (dec_alu)
    );

    // State register; reset always restarts at FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; all legality decisions are taken in DECODE.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                if (!instr_legal(op, funct3, funct7b5)) begin
                    state_next = S_ILLEGAL;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_RTYPE:          state_next = S_EXECR;
                        OP_ITYPE:          state_next = S_EXECI;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_JALR:           state_next = S_JALRADR;
                        OP_LUI:            state_next = S_LUI;
                        OP_AUIPC:          state_next = S_AUIPC;
                        default:           state_next = S_ILLEGAL;
                    endcase
                end
            end
            S_MEMADR:   state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_LUI:      state_next = S_ALUWB;
            S_AUIPC:    state_next = S_ALUWB;
            S_BRANCH:   state_next = S_FETCH;
            S_JALRADR:  state_next = S_JAL;
            S_JAL:      state_next = S_ALUWB;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls; held at idle values while reset is asserted so
    // an abandoned instruction can never complete a write.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        Illegal    = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                S_DECODE: begin
                    // Branch target (or jal target) is precomputed into ALUOut here.
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUControl = dec_alu;
                end
                S_EXECI: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = dec_alu;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                end
                S_LUI: begin
                    ALUSrcA = SRCA_ZERO;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_U;
                end
                S_AUIPC: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_U;
                end
                S_BRANCH: begin
                    // SUB for eq/ne, SLT for lt/ge; Zero is then read as equal or not-less.
                    ALUSrcA    = SRCA_RS1;
                    ALUControl = funct3[2] ? ALU_SLT : ALU_SUB;
                    case (funct3)
                        3'b000, 3'b101: PCWrite = Zero;
                        default:        PCWrite = !Zero;
                    endcase
                end
                S_JALRADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                S_JAL: begin
                    // PC takes the target held in ALUOut while the ALU forms the link value.
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
                S_ILLEGAL: begin
                    Illegal = 1'b1;
                end
                default: begin
                    Illegal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// tb/tb_rv32i_mc_controller.sv - self-checking bench for rv32i_mc_controller
module tb_rv32i_mc_controller;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    localparam int DC  = -1;
    localparam int ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4;
    localparam int SLT = 5, SLL = 6, SRL = 7, SRA = 8;

    typedef struct packed {
        logic [18:0] val;
        logic [18:0] mask;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [18:0] obs;

    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    rv32i_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Illegal    (Illegal)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected cycle; DC marks a select the instruction does not care about.
    function automatic void push(int pcw, int adr, int memw, int irw, int regw,
                                 int res, int sa, int sb, int imm, int alu, int ill);
        exp_t e;
        e = '0;
        e.val[18] = pcw[0];  e.mask[18] = 1'b1;
        e.val[16] = memw[0]; e.mask[16] = 1'b1;
        e.val[15] = irw[0];  e.mask[15] = 1'b1;
        e.val[14] = regw[0]; e.mask[14] = 1'b1;
        e.val[0]  = ill[0];  e.mask[0]  = 1'b1;
        if (adr >= 0) begin e.val[17] = adr[0];         e.mask[17]    = 1'b1; end
        if (res >= 0) begin e.val[13:12] = res[1:0];    e.mask[13:12] = 2'b11; end
        if (sa >= 0)  begin e.val[11:10] = sa[1:0];     e.mask[11:10] = 2'b11; end
        if (sb >= 0)  begin e.val[9:8] = sb[1:0];       e.mask[9:8]   = 2'b11; end
        if (imm >= 0) begin e.val[7:5] = imm[2:0];      e.mask[7:5]   = 3'b111; end
        if (alu >= 0) begin e.val[4:1] = alu[3:0];      e.mask[4:1]   = 4'b1111; end
        exp_q.push_back(e);
    endfunction

    function automatic int arith_op(bit rtype, int f3, bit f7);
        case (f3)
            0:       return (rtype && f7) ? SUB : ADD;
            1:       return SLL;
            2:       return SLT;
            4:       return XOR_;
            5:       return f7 ? SRA : SRL;
            6:       return OR_;
            default: return AND_;
        endcase
    endfunction

    // Builds the whole expected cycle sequence of one instruction from its class.
    function automatic void model(logic [6:0] o, int f3, bit f7, bit z);
        bit legal;
        bit take;
        case (o)
            T_LOAD, T_STORE: legal = (f3 == 2);
            T_R:             legal = (f3 != 3);
            T_I:             legal = (f3 != 3) && !(f3 == 1 && f7);
            T_BRANCH:        legal = (f3 == 0) || (f3 == 1) || (f3 == 4) || (f3 == 5);
            T_JAL, T_JALR, T_LUI, T_AUIPC: legal = 1'b1;
            default:         legal = 1'b0;
        endcase
        push(1, 0, 0, 1, 0, 2, 0, 2, DC, ADD, 0);
        push(0, DC, 0, 0, 0, DC, 1, 1, (o == T_JAL) ? 3 : 2, ADD, 0);
        if (!legal) begin
            for (int i = 0; i < 3; i++) push(0, DC, 0, 0, 0, DC, DC, DC, DC, DC, 1);
            return;
        end
        case (o)
            T_LOAD: begin
                push(0, DC, 0, 0, 0, DC, 2, 1, 0, ADD, 0);
                push(0, 1, 0, 0, 0, 0, DC, DC, DC, DC, 0);
                push(0, DC, 0, 0, 1, 1, DC, DC, DC, DC, 0);
            end
            T_STORE: begin
                push(0, DC, 0, 0, 0, DC, 2, 1, 1, ADD, 0);
                push(0, 1, 1, 0, 0, 0, DC, DC, DC, DC, 0);
            end
            T_R: begin
                push(0, DC, 0, 0, 0, DC, 2, 0, DC, arith_op(1'b1, f3, f7), 0);
                push(0, DC, 0, 0, 1, 0, DC, DC, DC, DC, 0);
            end
            T_I: begin
                push(0, DC, 0, 0, 0, DC, 2, 1, 0, arith_op(1'b0, f3, f7), 0);
                push(0, DC, 0, 0, 1, 0, DC, DC, DC, DC, 0);
            end
            T_LUI, T_AUIPC: begin
                push(0, DC, 0, 0, 0, DC, (o == T_LUI) ? 3 : 1, 1, 4, ADD, 0);
                push(0, DC, 0, 0, 1, 0, DC, DC, DC, DC, 0);
            end
            T_BRANCH: begin
                // eq and ge hold when the ALU result is zero; ne and lt when it is not.
                take = (f3 == 0 || f3 == 5) ? z : !z;
                push(take, DC, 0, 0, 0, 0, 2, 0, DC, (f3 >= 4) ? SLT : SUB, 0);
            end
            T_JALR: begin
                push(0, DC, 0, 0, 0, DC, 2, 1, 0, ADD, 0);
                push(1, DC, 0, 0, 0, 0, 1, 2, DC, ADD, 0);
                push(0, DC, 0, 0, 1, 0, DC, DC, DC, DC, 0);
            end
            default: begin
                push(1, DC, 0, 0, 0, 0, 1, 2, DC, ADD, 0);
                push(0, DC, 0, 0, 1, 0, DC, DC, DC, DC, 0);
            end
        endcase
    endfunction

    task automatic check(input string tag, input exp_t e);
        vectors++;
        assert ((obs & e.mask) === (e.val & e.mask))
        else begin
            miscompares++;
            $error("FAIL %s observed=%05h expected=%05h caremask=%05h", tag, obs & e.mask,
                   e.val & e.mask, e.mask);
        end
    endtask

    task automatic do_reset(input string tag, input int n);
        exp_t z;
        z.val  = '0;
        z.mask = '1;
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check($sformatf("%s_reset c%0d", tag, i), z);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f,
                             input logic f7, input logic z, input int maxc);
        int n;
        op       = o;
        funct3   = f;
        funct7b5 = f7;
        Zero     = z;
        exp_q.delete();
        model(o, int'(f), f7, z);
        n = (maxc < exp_q.size()) ? maxc : exp_q.size();
        for (int i = 0; i < n; i++) begin
            #1;
            check($sformatf("%s op=%b f3=%0d f7=%0d z=%0d c%0d", name, o, f, f7, z, i),
                  exp_q[i]);
            @(negedge clk);
        end
        if (n == exp_q.size() && exp_q[n-1].val[0]) do_reset({name, "_clear"}, 2);
    endtask

    initial begin
        logic [6:0] ro;
        logic [2:0] rf;
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        op       = '0;
        funct3   = '0;
        funct7b5 = 1'b0;
        Zero     = 1'b0;

        do_reset("power", 3);

        run_instr("add_pre", T_R, 3'b000, 1'b0, 1'b0, 2);
        do_reset("mid_execr", 3);

        run_instr("add",   T_R,      3'b000, 1'b0, 1'b0, 100);
        run_instr("sub",   T_R,      3'b000, 1'b1, 1'b0, 100);
        run_instr("srai",  T_I,      3'b101, 1'b1, 1'b0, 100);
        run_instr("addi7", T_I,      3'b000, 1'b1, 1'b0, 100);
        run_instr("beq",   T_BRANCH, 3'b000, 1'b0, 1'b1, 100);
        run_instr("bne",   T_BRANCH, 3'b001, 1'b0, 1'b1, 100);
        run_instr("blt",   T_BRANCH, 3'b100, 1'b0, 1'b0, 100);
        run_instr("lw",    T_LOAD,   3'b010, 1'b0, 1'b0, 100);
        run_instr("sw",    T_STORE,  3'b010, 1'b0, 1'b0, 100);
        run_instr("jal",   T_JAL,    3'b000, 1'b0, 1'b0, 100);
        run_instr("jalr",  T_JALR,   3'b000, 1'b0, 1'b0, 100);
        run_instr("lui",   T_LUI,    3'b000, 1'b0, 1'b0, 100);
        run_instr("auipc", T_AUIPC,  3'b000, 1'b0, 1'b0, 100);
        run_instr("sltu",  T_R,      3'b011, 1'b0, 1'b0, 100);
        run_instr("op0",   7'b0000000, 3'b000, 1'b0, 1'b0, 100);
        run_instr("slli7", T_I,      3'b001, 1'b1, 1'b0, 100);
        run_instr("bltu",  T_BRANCH, 3'b110, 1'b0, 1'b0, 100);

        for (int n = 0; n < 200; n++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: begin ro = T_LOAD;  if ($urandom_range(0, 3) != 0) rf = 3'b010; end
                1: begin ro = T_STORE; if ($urandom_range(0, 3) != 0) rf = 3'b010; end
                2: ro = T_R;
                3: ro = T_I;
                4: ro = T_BRANCH;
                5: ro = T_JAL;
                6: ro = T_JALR;
                7: ro = T_LUI;
                8: ro = T_AUIPC;
                default: ro = ($urandom_range(0, 1) != 0) ? 7'b1111111 : 7'b0001111;
            endcase
            run_instr($sformatf("rnd%0d", n), ro, rf, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
